// File: rtl/uart_rcv_os.sv
// 8N1 UART receiver (LSB first) with double-flop input sync, false-start
// rejection, one-cycle framing-error pulse and sticky overrun flag.
module uart_rcv_os #(
  parameter int BAUD_CNT = 2604,
  parameter int HALF_CNT = BAUD_CNT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [11:0] HALF_LD = 12'(HALF_CNT);
  localparam logic [11:0] BIT_LD  = 12'(BAUD_CNT - 1);

  logic        rx_meta_q, rx_meta_d;
  logic        rx_s_q, rx_s_d;
  logic        rx_dly_q, rx_dly_d;
  logic [1:0]  state_q, state_d;
  logic [11:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rdy_q, rdy_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        unread_q, unread_d;

  logic fall;
  logic sample;

  assign fall   = rx_dly_q & ~rx_s_q;
  assign sample = (baud_cnt_q == 12'd0);

  always_comb begin
    rx_meta_d   = RX;
    rx_s_d      = rx_meta_q;
    rx_dly_d    = rx_s_q;
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rdy_d       = rdy_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    unread_d    = unread_q;

    if (baud_cnt_q != 12'd0) begin
      baud_cnt_d = baud_cnt_q - 12'd1;
    end

    if (clr_rdy) begin
      rdy_d     = 1'b0;
      overrun_d = 1'b0;
      unread_d  = 1'b0;
    end

    // rdy drops at every start edge, so overrun tracks an unconsumed byte
    // through unread_q, which only clr_rdy (or reset) retires.
    case (state_q)
      IDLE: begin
        if (fall) begin
          baud_cnt_d = HALF_LD;
          rdy_d      = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (sample) begin
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            baud_cnt_d = BIT_LD;
            bit_cnt_d  = 4'd0;
            state_d    = DATA;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shift_d    = {rx_s_q, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 4'd1;
          baud_cnt_d = BIT_LD;
          if (bit_cnt_q == 4'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (sample) begin
          if (rx_s_q) begin
            rx_data_d = shift_q;
            rdy_d     = 1'b1;
            unread_d  = 1'b1;
            if (unread_q && !clr_rdy) begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_dly_q    <= 1'b1;
      state_q     <= IDLE;
      baud_cnt_q  <= 12'd0;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      unread_q    <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      rx_dly_q    <= rx_dly_d;
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rdy_q       <= rdy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      unread_q    <= unread_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rdy       = rdy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rcv_os.sv
// Directed bench for uart_rcv_os: a short-baud instance for most scenarios
// and a default-baud instance for the nominal 19200-baud latency.
module tb_uart_rcv_os;

  localparam int B = 64;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frame_err;
  logic       overrun;

  logic       rx_full;
  logic       clr_full;
  logic [7:0] rx_data_full;
  logic       rdy_full;
  logic       frame_err_full;
  logic       overrun_full;

  int total;
  int passed;
  int fe_cnt;
  int fe_full_cnt;
  int rise_cnt;
  logic rdy_prev;

  uart_rcv_os #(.BAUD_CNT(B)) dut (
    .clk      (clk),
    .rst      (rst),
    .RX       (rx),
    .clr_rdy  (clr_rdy),
    .rx_data  (rx_data),
    .rdy      (rdy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  uart_rcv_os dut_full (
    .clk      (clk),
    .rst      (rst),
    .RX       (rx_full),
    .clr_rdy  (clr_full),
    .rx_data  (rx_data_full),
    .rdy      (rdy_full),
    .frame_err(frame_err_full),
    .overrun  (overrun_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitors sampled away from the active edge
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (frame_err_full === 1'b1) fe_full_cnt++;
    if (rdy === 1'b1 && rdy_prev !== 1'b1) rise_cnt++;
    rdy_prev = rdy;
  end

  initial begin
    #(10 * 90000);
    $display("[TB] FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic set_rx(input logic full, input logic v);
    if (full) rx_full = v;
    else rx = v;
  endtask

  task automatic send_frame(input logic full, input int baud, input logic [7:0] d, input logic stop_bit);
    set_rx(full, 1'b0);
    repeat (baud) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rx(full, d[i]);
      repeat (baud) @(negedge clk);
    end
    set_rx(full, stop_bit);
    repeat (baud) @(negedge clk);
    set_rx(full, 1'b1);
    repeat (baud) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rx_full = 1'b1; clr_rdy = 1'b0; clr_full = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (rx_data !== 8'h00) $display("[TB] FAIL reset_rx_data: got %h want 00", rx_data); else passed++;
    total++; if (rdy !== 1'b0) $display("[TB] FAIL reset_rdy: got %b want 0", rdy); else passed++;
    total++; if (frame_err !== 1'b0) $display("[TB] FAIL reset_frame_err: got %b want 0", frame_err); else passed++;
    total++; if (overrun !== 1'b0) $display("[TB] FAIL reset_overrun: got %b want 0", overrun); else passed++;
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_nominal_baud();
    int lat;
    fe_full_cnt = 0;
    lat = 0;
    fork
      send_frame(1'b1, 2604, 8'h67, 1'b1);
      begin
        while (rdy_full !== 1'b1 && lat < 30000) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    total++; if (lat < 24736 || lat > 24742) $display("[TB] FAIL nominal_latency: got %0d want 24739+-3", lat); else passed++;
    total++; if (rx_data_full !== 8'h67) $display("[TB] FAIL nominal_data: got %h want 67", rx_data_full); else passed++;
    total++; if (fe_full_cnt !== 0) $display("[TB] FAIL nominal_frame_err: got %0d pulses want 0", fe_full_cnt); else passed++;
    clr_full = 1'b1;
    @(negedge clk);
    clr_full = 1'b0;
    total++; if (rdy_full !== 1'b0) $display("[TB] FAIL nominal_clr: rdy got %b want 0", rdy_full); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat;
    rise_cnt = 0;
    lat = 0;
    fork
      send_frame(1'b0, B, 8'h67, 1'b1);
      begin
        while (rdy !== 1'b1 && lat < 2000) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    total++; if (lat < 610 || lat > 612) $display("[TB] FAIL b2b_latency: got %0d want 611+-1", lat); else passed++;
    total++; if (rx_data !== 8'h67) $display("[TB] FAIL b2b_data0: got %h want 67", rx_data); else passed++;
    total++; if (rdy !== 1'b1) $display("[TB] FAIL b2b_rdy0: got %b want 1", rdy); else passed++;
    pulse_clr();
    total++; if (rdy !== 1'b0) $display("[TB] FAIL b2b_clr0: rdy got %b want 0", rdy); else passed++;
    send_frame(1'b0, B, 8'h73, 1'b1);
    total++; if (rx_data !== 8'h73) $display("[TB] FAIL b2b_data1: got %h want 73", rx_data); else passed++;
    total++; if (rdy !== 1'b1) $display("[TB] FAIL b2b_rdy1: got %b want 1", rdy); else passed++;
    pulse_clr();
    total++; if (rise_cnt !== 2) $display("[TB] FAIL b2b_rdy_count: got %0d want 2", rise_cnt); else passed++;
    total++; if (overrun !== 1'b0) $display("[TB] FAIL b2b_overrun: got %b want 0", overrun); else passed++;
  endtask

  task automatic test_false_start();
    fe_cnt = 0;
    rise_cnt = 0;
    rx = 1'b0;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    total++; if (rdy !== 1'b0) $display("[TB] FAIL glitch_rdy: got %b want 0", rdy); else passed++;
    total++; if (fe_cnt !== 0) $display("[TB] FAIL glitch_frame_err: got %0d pulses want 0", fe_cnt); else passed++;
    total++; if (rise_cnt !== 0) $display("[TB] FAIL glitch_rdy_count: got %0d want 0", rise_cnt); else passed++;
    total++; if (rx_data !== 8'h73) $display("[TB] FAIL glitch_data_kept: got %h want 73", rx_data); else passed++;
    send_frame(1'b0, B, 8'h73, 1'b1);
    total++; if (rx_data !== 8'h73) $display("[TB] FAIL glitch_next_data: got %h want 73", rx_data); else passed++;
    total++; if (rise_cnt !== 1) $display("[TB] FAIL glitch_next_rdy_count: got %0d want 1", rise_cnt); else passed++;
    total++; if (fe_cnt !== 0) $display("[TB] FAIL glitch_next_frame_err: got %0d want 0", fe_cnt); else passed++;
    pulse_clr();
  endtask

  task automatic test_frame_err();
    fe_cnt = 0;
    send_frame(1'b0, B, 8'h55, 1'b0);
    total++; if (fe_cnt !== 1) $display("[TB] FAIL ferr_pulse_cycles: got %0d want 1", fe_cnt); else passed++;
    total++; if (rdy !== 1'b0) $display("[TB] FAIL ferr_rdy: got %b want 0", rdy); else passed++;
    total++; if (rx_data !== 8'h73) $display("[TB] FAIL ferr_data_kept: got %h want 73", rx_data); else passed++;
    total++; if (overrun !== 1'b0) $display("[TB] FAIL ferr_overrun: got %b want 0", overrun); else passed++;
  endtask

  task automatic test_overrun();
    send_frame(1'b0, B, 8'hA5, 1'b1);
    total++; if (rx_data !== 8'hA5) $display("[TB] FAIL ovr_data0: got %h want a5", rx_data); else passed++;
    total++; if (rdy !== 1'b1) $display("[TB] FAIL ovr_rdy0: got %b want 1", rdy); else passed++;
    total++; if (overrun !== 1'b0) $display("[TB] FAIL ovr_early: got %b want 0", overrun); else passed++;
    fork
      send_frame(1'b0, B, 8'h3C, 1'b1);
      begin
        repeat (B) @(negedge clk);
        total++; if (rdy !== 1'b0) $display("[TB] FAIL ovr_start_clears_rdy: got %b want 0", rdy); else passed++;
      end
    join
    total++; if (overrun !== 1'b1) $display("[TB] FAIL ovr_set: got %b want 1", overrun); else passed++;
    total++; if (rx_data !== 8'h3C) $display("[TB] FAIL ovr_data1: got %h want 3c", rx_data); else passed++;
    total++; if (rdy !== 1'b1) $display("[TB] FAIL ovr_rdy1: got %b want 1", rdy); else passed++;
    pulse_clr();
    total++; if (rdy !== 1'b0) $display("[TB] FAIL ovr_clr_rdy: got %b want 0", rdy); else passed++;
    total++; if (overrun !== 1'b0) $display("[TB] FAIL ovr_clr_overrun: got %b want 0", overrun); else passed++;
    // rdy is set on the 612th rising edge after the start bit is driven
    fork
      send_frame(1'b0, B, 8'h5A, 1'b1);
      begin
        repeat (611) @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
      end
    join
    total++; if (rdy !== 1'b1) $display("[TB] FAIL coll0_rdy: got %b want 1", rdy); else passed++;
    total++; if (overrun !== 1'b0) $display("[TB] FAIL coll0_overrun: got %b want 0", overrun); else passed++;
    total++; if (rx_data !== 8'h5A) $display("[TB] FAIL coll0_data: got %h want 5a", rx_data); else passed++;
    fork
      send_frame(1'b0, B, 8'hC3, 1'b1);
      begin
        repeat (611) @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
      end
    join
    total++; if (rdy !== 1'b1) $display("[TB] FAIL coll1_rdy: got %b want 1", rdy); else passed++;
    total++; if (overrun !== 1'b0) $display("[TB] FAIL coll1_overrun: got %b want 0", overrun); else passed++;
    total++; if (rx_data !== 8'hC3) $display("[TB] FAIL coll1_data: got %h want c3", rx_data); else passed++;
  endtask

  task automatic test_mid_reset();
    fe_cnt = 0;
    send_frame(1'b0, B, 8'h11, 1'b1);
    total++; if (overrun !== 1'b1) $display("[TB] FAIL mrst_pre_overrun: got %b want 1", overrun); else passed++;
    total++; if (rx_data !== 8'h11) $display("[TB] FAIL mrst_pre_data: got %h want 11", rx_data); else passed++;
    rx = 1'b0;
    repeat (B) @(negedge clk);
    rx = 1'b1;
    repeat (4 * B + B / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (rx_data !== 8'h00) $display("[TB] FAIL mrst_data: got %h want 00", rx_data); else passed++;
    total++; if (rdy !== 1'b0) $display("[TB] FAIL mrst_rdy: got %b want 0", rdy); else passed++;
    total++; if (overrun !== 1'b0) $display("[TB] FAIL mrst_overrun: got %b want 0", overrun); else passed++;
    total++; if (frame_err !== 1'b0) $display("[TB] FAIL mrst_frame_err: got %b want 0", frame_err); else passed++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (B) @(negedge clk);
    send_frame(1'b0, B, 8'h67, 1'b1);
    total++; if (rx_data !== 8'h67) $display("[TB] FAIL mrst_after_data: got %h want 67", rx_data); else passed++;
    total++; if (rdy !== 1'b1) $display("[TB] FAIL mrst_after_rdy: got %b want 1", rdy); else passed++;
    total++; if (overrun !== 1'b0) $display("[TB] FAIL mrst_after_overrun: got %b want 0", overrun); else passed++;
    total++; if (fe_cnt !== 0) $display("[TB] FAIL mrst_after_frame_err: got %0d want 0", fe_cnt); else passed++;
  endtask

  initial begin
    total = 0;
    passed = 0;
    fe_cnt = 0;
    fe_full_cnt = 0;
    rise_cnt = 0;
    rdy_prev = 1'b0;
    rst = 1'b1;
    rx = 1'b1;
    rx_full = 1'b1;
    clr_rdy = 1'b0;
    clr_full = 1'b0;
    @(negedge clk);
    test_reset();
    test_nominal_baud();
    test_back_to_back();
    test_false_start();
    test_frame_err();
    test_overrun();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
